// File: rtl/sram_port_master.sv
`default_nettype none
// ============================================================================
// sram_port_master : synchronous burst master for an asynchronous single-port
//                    RAM with a shared bidirectional data bus
// Revision 1.0
// ============================================================================
module sram_port_master #(
  parameter int AW         = 4,
  parameter int DW         = 8,
  parameter int ACCESS_CYC = 2
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          req_in,
  input  logic          rw_in,
  input  logic [AW-1:0] addr_in,
  input  logic [AW-1:0] len_in,
  input  logic [DW-1:0] wdata_in,
  input  logic          wvalid_in,
  output logic          wready_out,
  output logic [DW-1:0] rdata_out,
  output logic          rvalid_out,
  output logic          busy_out,
  output logic          done_out,
  output logic [AW-1:0] mem_addr_out,
  output logic          mem_we_out,
  output logic          mem_enable_out,
  inout  wire  [DW-1:0] mem_data
);

  localparam int CW = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;
  localparam logic [CW-1:0] c_acc_last = CW'(ACCESS_CYC - 1);

  localparam logic [2:0] c_idle    = 3'd0;
  localparam logic [2:0] c_setup   = 3'd1;
  localparam logic [2:0] c_access  = 3'd2;
  localparam logic [2:0] c_recover = 3'd3;
  localparam logic [2:0] c_done    = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic          r_rw;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_beats;
  logic [CW-1:0] r_acc_cnt;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          r_rvalid;
  logic          w_acc_last;
  logic          w_more_beats;

  assign w_acc_last   = (r_acc_cnt == c_acc_last);
  assign w_more_beats = (r_beats != '0);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:    if (req_in) w_state_nxt = c_setup;
      c_setup:   if (!r_rw || wvalid_in) w_state_nxt = c_access;
      c_access:  if (w_acc_last) w_state_nxt = c_recover;
      c_recover: w_state_nxt = w_more_beats ? c_setup : c_done;
      c_done:    w_state_nxt = c_idle;
      default:   w_state_nxt = c_idle;
    endcase
  end

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    wready_out     = 1'b0;
    mem_we_out     = 1'b0;
    mem_enable_out = 1'b0;
    busy_out       = (r_state != c_idle);
    done_out       = (r_state == c_done);
    case (r_state)
      c_setup:  wready_out = r_rw;
      c_access: begin
        mem_we_out     = r_rw;
        mem_enable_out = !r_rw;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rw      <= 1'b0;
      r_addr    <= '0;
      r_beats   <= '0;
      r_acc_cnt <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
    end else begin
      r_rvalid <= (r_state == c_access) && !r_rw && w_acc_last;
      case (r_state)
        c_idle: begin
          if (req_in) begin
            r_rw    <= rw_in;
            r_addr  <= addr_in;
            r_beats <= len_in;
          end
        end
        c_setup: begin
          r_acc_cnt <= '0;
          if (r_rw && wvalid_in) r_wdata <= wdata_in;
        end
        c_access: begin
          r_acc_cnt <= w_acc_last ? '0 : r_acc_cnt + CW'(1);
          if (!r_rw && w_acc_last) r_rdata <= mem_data;
        end
        c_recover: begin
          // Address advances only here, after both strobes have dropped.
          if (w_more_beats) begin
            r_beats <= r_beats - AW'(1);
            r_addr  <= r_addr + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr_out = r_addr;
  assign rdata_out    = r_rdata;
  assign rvalid_out   = r_rvalid;
  assign mem_data     = (mem_we_out && !mem_enable_out) ? r_wdata : {DW{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_sram_port_master.sv
`default_nettype none
// ============================================================================
// tb_sram_port_master : directed bench with a 16x8 RAM model and bus monitor
// Revision 1.0
// ============================================================================
module tb_sram_port_master;

  logic       clk;
  logic       rst_n_in;
  logic       req_in;
  logic       rw_in;
  logic [3:0] addr_in;
  logic [3:0] len_in;
  logic [7:0] wdata_in;
  logic       wvalid_in;
  logic       wready_out;
  logic [7:0] rdata_out;
  logic       rvalid_out;
  logic       busy_out;
  logic       done_out;
  logic [3:0] mem_addr_out;
  logic       mem_we_out;
  logic       mem_enable_out;
  wire  [7:0] mem_data;

  logic [7:0] ram [16];
  int         n_vec;
  int         n_err;
  logic       cur_rw;

  sram_port_master #(.AW(4), .DW(8), .ACCESS_CYC(2)) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n_in),
    .req_in         (req_in),
    .rw_in          (rw_in),
    .addr_in        (addr_in),
    .len_in         (len_in),
    .wdata_in       (wdata_in),
    .wvalid_in      (wvalid_in),
    .wready_out     (wready_out),
    .rdata_out      (rdata_out),
    .rvalid_out     (rvalid_out),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .mem_addr_out   (mem_addr_out),
    .mem_we_out     (mem_we_out),
    .mem_enable_out (mem_enable_out),
    .mem_data       (mem_data)
  );

  // RAM model: drives the bus only while read-enabled, captures while written
  assign mem_data = (mem_enable_out && !mem_we_out) ? ram[mem_addr_out] : 8'bz;

  always @(posedge clk) begin
    if (mem_we_out) ram[mem_addr_out] <= mem_data;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rw;
    logic [3:0] addr;
    logic [3:0] len;
    logic [7:0] base;
    logic [7:0] step;
    int         stall;
    logic       poke;
    int         exp_cycles;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin : monitor
    logic [3:0] prev_addr;
    logic       prev_strobe;
    logic       prev_valid;
    prev_addr   = '0;
    prev_strobe = 1'b0;
    prev_valid  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n_in) begin
        prev_valid = 1'b0;
      end else begin
        if (mem_we_out && mem_enable_out) begin
          n_err++;
          $display("FAIL protocol overlap: we=%0b en=%0b both high", mem_we_out, mem_enable_out);
        end
        if (prev_valid && (mem_addr_out != prev_addr) &&
            (prev_strobe || mem_we_out || mem_enable_out)) begin
          n_err++;
          $display("FAIL protocol addr-under-strobe: addr %0h -> %0h, required stable", prev_addr, mem_addr_out);
        end
        if (rvalid_out && cur_rw) begin
          n_err++;
          $display("FAIL protocol rvalid-in-write: rvalid=1, required 0");
        end
        prev_valid = 1'b1;
      end
      prev_addr   = mem_addr_out;
      prev_strobe = mem_we_out | mem_enable_out;
    end
  end

  task automatic run_burst(input vec_t v, input string tag);
    int         wbeat, rbeat, stall_left, rvalids;
    bit         seen_done;
    logic [7:0] exp_d;
    logic [3:0] a;
    wbeat = 0; rbeat = 0; rvalids = 0; stall_left = v.stall; seen_done = 0;
    @(negedge clk);
    cur_rw    = v.rw;
    req_in    = 1'b1;
    rw_in     = v.rw;
    addr_in   = v.addr;
    len_in    = v.len;
    wvalid_in = 1'b0;
    @(posedge clk);
    #1;
    // Optionally keep requesting a conflicting command for the whole burst
    req_in  = v.poke;
    rw_in   = ~v.rw;
    addr_in = v.addr + 4'd8;
    len_in  = 4'd0;
    for (int cyc = 1; cyc <= 200 && !seen_done; cyc++) begin
      @(negedge clk);
      if (rvalid_out) begin
        rvalids++;
        exp_d = v.base + 8'(rbeat) * v.step;
        check({tag, " rdata"}, rdata_out, exp_d);
        rbeat++;
      end
      if (mem_we_out || mem_enable_out) begin
        a = v.addr + 4'(v.rw ? wbeat - 1 : rbeat);
        check({tag, " mem_addr"}, mem_addr_out, a);
      end
      if (done_out) begin
        seen_done = 1;
        check({tag, " latency"}, cyc, v.exp_cycles);
        req_in = 1'b0;
      end
      if (wready_out) begin
        if (stall_left > 0) begin
          check({tag, " stall we/addr"}, {mem_we_out, mem_addr_out}, {1'b0, v.addr + 4'(wbeat)});
          wvalid_in = 1'b0;
          stall_left--;
        end else begin
          wvalid_in = 1'b1;
          wdata_in  = v.base + 8'(wbeat) * v.step;
          wbeat++;
        end
      end else begin
        // junk write data outside SETUP must be ignored
        wvalid_in = 1'b1;
        wdata_in  = 8'hEE;
      end
    end
    wvalid_in = 1'b0;
    req_in    = 1'b0;
    check({tag, " done seen"}, seen_done, 1);
    check({tag, " beats"}, v.rw ? wbeat : rvalids, 32'(v.len) + 1);
    @(negedge clk);
    check({tag, " idle after done"}, {busy_out, done_out}, 2'b00);
    if (v.rw) begin
      for (int i = 0; i <= int'(v.len); i++) begin
        a     = v.addr + 4'(i);
        exp_d = v.base + 8'(i) * v.step;
        check({tag, " ram"}, ram[a], exp_d);
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0; n_err = 0; cur_rw = 1'b0;
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    rst_n_in = 1'b0; req_in = 1'b0; rw_in = 1'b0; addr_in = '0;
    len_in = '0; wdata_in = '0; wvalid_in = 1'b0;

    //          rw    addr   len    base   step  stall poke cycles
    vecs[0] = '{1'b1, 4'd0,  4'd15, 8'h00, 8'h01, 0, 1'b0, 65};
    vecs[1] = '{1'b0, 4'd0,  4'd15, 8'h00, 8'h01, 0, 1'b0, 65};
    vecs[2] = '{1'b1, 4'd14, 4'd3,  8'hAA, 8'h11, 0, 1'b0, 17};
    vecs[3] = '{1'b0, 4'd14, 4'd3,  8'hAA, 8'h11, 0, 1'b1, 17};
    vecs[4] = '{1'b1, 4'd5,  4'd15, 8'h40, 8'h03, 0, 1'b1, 65};
    vecs[5] = '{1'b0, 4'd5,  4'd15, 8'h40, 8'h03, 0, 1'b0, 65};
    vecs[6] = '{1'b1, 4'd7,  4'd0,  8'h5A, 8'h00, 0, 1'b0, 5};
    vecs[7] = '{1'b0, 4'd7,  4'd0,  8'h5A, 8'h00, 0, 1'b0, 5};
    vecs[8] = '{1'b1, 4'd3,  4'd1,  8'h77, 8'h01, 5, 1'b0, 14};
    vecs[9] = '{1'b0, 4'd3,  4'd1,  8'h77, 8'h01, 0, 1'b0, 9};

    repeat (3) @(negedge clk);
    check("reset outputs",
          {wready_out, rvalid_out, busy_out, done_out, mem_we_out, mem_enable_out}, 6'b0);
    check("reset rdata", rdata_out, 8'h00);
    check("reset addr", mem_addr_out, 4'h0);
    rst_n_in = 1'b1;

    for (int i = 0; i < 10; i++) run_burst(vecs[i], $sformatf("v%0d", i));

    // Async reset in the middle of a write strobe
    @(negedge clk);
    cur_rw = 1'b1; req_in = 1'b1; rw_in = 1'b1; addr_in = 4'd9; len_in = 4'd2;
    wvalid_in = 1'b1; wdata_in = 8'h3C;
    @(posedge clk);
    #1 req_in = 1'b0;
    for (int n = 0; n < 20 && !mem_we_out; n++) @(negedge clk);
    check("midwrite strobe reached", mem_we_out, 1);
    #2 rst_n_in = 1'b0;
    #1;
    check("midwrite reset strobes/busy",
          {mem_we_out, mem_enable_out, busy_out, wready_out, done_out, rvalid_out}, 6'b0);
    check("midwrite reset addr", mem_addr_out, 4'h0);
    wvalid_in = 1'b0;
    @(negedge clk);
    #3 rst_n_in = 1'b1;
    check("midwrite idle after release", busy_out, 0);

    run_burst(vecs[7], "post-reset read");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_port_master.md
Name: sram_port_master

Overview:
- Synchronous master that drives the asynchronous single-port RAM interface: address, write strobe, read enable and a shared bidirectional 8-bit data bus.
- Accepts single or burst read/write commands from a client.
- Sequences setup, access and recovery phases so the strobes never overlap and the bus never has two drivers.
- Sits between on-chip client logic and the 16x8 RAM.

Parameters:
AW, 4, address width; RAM depth is 2^AW.
DW, 8, data width.
ACCESS_CYC, 2, cycles a strobe is held per beat (min 1).

Ports:
clk_in  input  1  clock; all logic on rising edge.
rst_n_in  input  1  asynchronous, active-low reset.
req_in  input  1  command request; sampled only in IDLE.
rw_in  input  1  1 = write burst, 0 = read burst; sampled with req_in.
addr_in  input  AW  burst start address.
len_in  input  AW  beats minus 1 (0 = 1 beat, 15 = 16 beats).
wdata_in  input  DW  write beat data.
wvalid_in  input  1  wdata_in valid.
wready_out  output  1  master accepts wdata_in this cycle.
rdata_out  output  DW  read beat data.
rvalid_out  output  1  one-cycle pulse; rdata_out valid.
busy_out  output  1  high from command accept to end of DONE.
done_out  output  1  one-cycle pulse at burst end.
mem_addr_out  output  AW  RAM address.
mem_we_out  output  1  RAM write strobe.
mem_enable_out  output  1  RAM read enable.
mem_data  inout  DW  RAM data bus; master drives it only while mem_we_out=1 and mem_enable_out=0, otherwise high-Z.

Behaviour:
- Reset (async, any state):
  - State = IDLE.
  - All outputs 0: wready_out, rvalid_out, busy_out, done_out, mem_we_out, mem_enable_out, rdata_out, mem_addr_out.
  - mem_data released to Z immediately.
  - Beat counter and address register cleared.
- States: IDLE, SETUP, ACCESS, RECOVER, DONE.
- IDLE:
  - On req_in=1, latch rw_in, addr_in and len_in.
  - Drive mem_addr_out = addr_in; busy_out=1; go to SETUP.
- SETUP:
  - Address stable, mem_we_out=0, mem_enable_out=0, bus Z.
  - Read: go to ACCESS next cycle.
  - Write: wready_out=1 combinationally in this state. If wvalid_in=1, capture wdata_in and go to ACCESS; otherwise stay in SETUP (stall, no timeout).
- ACCESS (ACCESS_CYC cycles):
  - Write: mem_we_out=1 and mem_data driven with the captured data.
  - Read: mem_enable_out=1 and bus Z. On the last ACCESS cycle, register mem_data into rdata_out; rvalid_out pulses the following cycle.
  - Then go to RECOVER.
- RECOVER (1 cycle):
  - Both strobes 0 and bus Z; this is the turnaround cycle.
  - If beats remain: mem_addr_out increments by 1 modulo 2^AW (15 wraps to 0), then SETUP.
  - If no beats remain: DONE.
- DONE (1 cycle): done_out=1 and busy_out=1; then IDLE with busy_out=0.
- Invariants:
  - mem_we_out and mem_enable_out are never both 1.
  - mem_addr_out changes only in IDLE or on RECOVER exit, never while a strobe is high.
- Latency:
  - Read beat: 1 + ACCESS_CYC + 1 cycles.
  - Write beat: the same, plus any wvalid_in stall.
  - A 1-beat read at ACCESS_CYC=2 gives done_out 5 cycles after req_in is sampled.
- req_in while busy_out=1: ignored; no queuing.
- len_in=15 from addr_in=5: addresses 5..15, then 0..4; exactly 16 beats.
- wvalid_in outside SETUP: ignored. rvalid_out never asserts during a write burst.

Test Plan:
1. Reset mid-write: assert rst_n_in low during ACCESS with mem_we_out=1 -> mem_we_out=0 and mem_data=Z in the same cycle; state IDLE; busy_out=0.
2. Write 16-beat burst: addr_in=0, len_in=15, wdata = beat index 0..15 with wvalid_in held high -> RAM locations 0..15 hold 0..15; done_out pulses once; each beat is 4 cycles at ACCESS_CYC=2.
3. Read back 16 beats from address 0 -> 16 rvalid_out pulses with rdata_out 0,1,...,15 in order; mem_data is never driven by the master.
4. Wrap-around: write len_in=3 at addr_in=14 with data AA,BB,CC,DD -> addresses 14,15,0,1 are written; a read-back returns AA,BB,CC,DD.
5. Write stall: hold wvalid_in=0 for 5 cycles in SETUP -> wready_out stays 1; no strobe and address unchanged; write completes once wvalid_in=1.
6. Protocol checker over all tests: never mem_we_out & mem_enable_out; no address change while a strobe is high; req_in during busy_out=1 is ignored.
